// File: rtl/led_pkg.sv
// Shared constants and state encodings for the HUB75 panel scanner.
package led_pkg;

    localparam int unsigned PANEL_COLS      = 64;
    localparam int unsigned PANEL_SCAN_ROWS = 32;
    localparam int unsigned PIX_PHASES      = 3;

    localparam int unsigned COL_W = $clog2(PANEL_COLS);
    localparam int unsigned ROW_W = $clog2(PANEL_SCAN_ROWS);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} scan_state_t;
    typedef enum logic [1:0] {ADDR, SETUP, CLK} pix_phase_t;

endpackage

// File: rtl/led_pwm_gate.sv
// Display-window counter and brightness compare driving the panel output enable.
module led_pwm_gate #(
    parameter int unsigned ON_CYCLES = 256,
    parameter int unsigned BRIGHT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                active,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic                last,
    output logic                pre_last,
    output logic                oe_n
);

    localparam int unsigned CNT_W = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;

    logic [CNT_W-1:0]    disp_cnt;
    logic [BRIGHT_W-1:0] bright_q;
    logic [31:0]         cnt_nxt;

    assign cnt_nxt  = 32'(disp_cnt) + 32'd1;
    assign last     = (32'(disp_cnt) == ON_CYCLES - 1);
    assign pre_last = (32'(disp_cnt) == ON_CYCLES - 2);

    // oe_n is registered, so it is computed for the count the next cycle will hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_cnt <= '0;
            bright_q <= '0;
            oe_n     <= 1'b1;
        end else if (start) begin
            bright_q <= brightness;
            disp_cnt <= '0;
            oe_n     <= (brightness == '0);
        end else if (active) begin
            if (last) begin
                disp_cnt <= '0;
                oe_n     <= 1'b1;
            end else begin
                disp_cnt <= disp_cnt + CNT_W'(1);
                oe_n     <= !(cnt_nxt < 32'(bright_q));
            end
        end else begin
            oe_n <= 1'b1;
        end
    end

endmodule

// File: rtl/led_panel_scan.sv
// Framebuffer-to-HUB75 scanner: shifts one column per pixel, latches a row, then PWM-displays it.
module led_panel_scan
    import led_pkg::*;
#(
    parameter int unsigned COLS      = PANEL_COLS,
    parameter int unsigned SCAN_ROWS = PANEL_SCAN_ROWS,
    parameter int unsigned ON_CYCLES = 256,
    parameter int unsigned BRIGHT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic [COL_W-1:0]    fb_col_addr,
    input  logic [63:0]         fb_col_data,
    output logic                pnl_clk,
    output logic                pnl_r1,
    output logic                pnl_r2,
    output logic                pnl_lat,
    output logic                pnl_oe_n,
    output logic [ROW_W-1:0]    pnl_addr,
    output logic                frame_start,
    output logic                frame_done,
    output logic                busy
);

    scan_state_t      state;
    pix_phase_t       phase;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [5:0]       hi_idx;
    logic             disp_last;
    logic             disp_pre_last;
    logic             last_row;

    assign hi_idx   = 6'(row) + 6'(SCAN_ROWS);
    assign last_row = (row == ROW_W'(SCAN_ROWS - 1));

    led_pwm_gate #(
        .ON_CYCLES (ON_CYCLES),
        .BRIGHT_W  (BRIGHT_W)
    ) u_pwm_gate (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (state == LATCH),
        .active     (state == DISPLAY),
        .brightness (brightness),
        .last       (disp_last),
        .pre_last   (disp_pre_last),
        .oe_n       (pnl_oe_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= ADDR;
            col         <= '0;
            row         <= '0;
            fb_col_addr <= '0;
            pnl_clk     <= 1'b0;
            pnl_r1      <= 1'b0;
            pnl_r2      <= 1'b0;
            pnl_lat     <= 1'b0;
            pnl_addr    <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            pnl_lat     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state       <= SHIFT;
                        phase       <= ADDR;
                        row         <= '0;
                        col         <= '0;
                        fb_col_addr <= '0;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                SHIFT: begin
                    unique case (phase)
                        ADDR: phase <= SETUP;
                        // RAM data for fb_col_addr is valid in this cycle
                        SETUP: begin
                            pnl_r1  <= fb_col_data[row];
                            pnl_r2  <= fb_col_data[hi_idx];
                            pnl_clk <= 1'b1;
                            phase   <= CLK;
                        end
                        CLK: begin
                            pnl_clk <= 1'b0;
                            phase   <= ADDR;
                            if (col == COL_W'(COLS - 1)) begin
                                col      <= '0;
                                state    <= LATCH;
                                pnl_lat  <= 1'b1;
                                pnl_addr <= row;
                            end else begin
                                col         <= col + 1'b1;
                                fb_col_addr <= col + 1'b1;
                            end
                        end
                        default: phase <= ADDR;
                    endcase
                end
                LATCH: state <= DISPLAY;
                DISPLAY: begin
                    if (disp_last) begin
                        fb_col_addr <= '0;
                        phase       <= ADDR;
                        if (!last_row) begin
                            row   <= row + 1'b1;
                            state <= SHIFT;
                        end else begin
                            row <= '0;
                            if (enable) begin
                                state       <= SHIFT;
                                frame_start <= 1'b1;
                            end else begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                pnl_r1   <= 1'b0;
                                pnl_r2   <= 1'b0;
                                pnl_addr <= '0;
                            end
                        end
                    end else if (disp_pre_last && last_row) begin
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_panel_scan.sv
// Directed self-checking bench for led_panel_scan with a synchronous framebuffer model.
module tb_led_panel_scan;

    localparam int ROW_LEN = 449;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  brightness;
    logic [5:0]  fb_col_addr;
    logic [63:0] fb_col_data;
    logic        pnl_clk, pnl_r1, pnl_r2, pnl_lat, pnl_oe_n;
    logic [4:0]  pnl_addr;
    logic        frame_start, frame_done, busy;

    logic [63:0] fb_mem [64];

    int n_checks = 0;
    int n_errors = 0;

    int r_rises, r_lat_at, r_lat_cnt, r_addr, r_oe_cnt, r_oe_first;
    int r_fs_cnt, r_fd_at, r_fd_cnt;
    logic [63:0] r_r1, r_r2;
    int fs_sum, fd_sum, busy_sum;

    led_panel_scan u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .brightness  (brightness),
        .fb_col_addr (fb_col_addr),
        .fb_col_data (fb_col_data),
        .pnl_clk     (pnl_clk),
        .pnl_r1      (pnl_r1),
        .pnl_r2      (pnl_r2),
        .pnl_lat     (pnl_lat),
        .pnl_oe_n    (pnl_oe_n),
        .pnl_addr    (pnl_addr),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) fb_col_data <= fb_mem[fb_col_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered at the negedge of a row's first ADDR cycle; leaves at the next row's.
    task automatic run_row(input int sw_at, input logic [7:0] sw_val);
        logic prev_clk;
        prev_clk   = 1'b0;
        r_rises    = 0;
        r_lat_at   = -1;
        r_lat_cnt  = 0;
        r_addr     = -1;
        r_oe_cnt   = 0;
        r_oe_first = -1;
        r_fs_cnt   = 0;
        r_fd_at    = -1;
        r_fd_cnt   = 0;
        r_r1       = '0;
        r_r2       = '0;
        for (int i = 0; i < ROW_LEN; i++) begin
            if (i == sw_at) brightness = sw_val;
            if (pnl_clk && !prev_clk) begin
                if (r_rises < 64) begin
                    r_r1[r_rises] = pnl_r1;
                    r_r2[r_rises] = pnl_r2;
                end
                r_rises++;
            end
            prev_clk = pnl_clk;
            if (pnl_lat) begin
                r_lat_cnt++;
                r_lat_at = i;
                r_addr   = int'(pnl_addr);
            end
            if (!pnl_oe_n) begin
                if (r_oe_cnt == 0) r_oe_first = i;
                r_oe_cnt++;
            end
            if (frame_start) r_fs_cnt++;
            if (frame_done) begin
                r_fd_cnt++;
                r_fd_at = i;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        for (int c = 0; c < 64; c++) fb_mem[c] = '0;
        fb_mem[5] = 64'h0000_0001_0000_0008;
        rst_n      = 1'b0;
        enable     = 1'b0;
        brightness = 8'd100;
        repeat (3) @(negedge clk);

        check("rst_busy", busy, 1'b0);
        check("rst_oe_n", pnl_oe_n, 1'b1);
        check("rst_ctl", {pnl_clk, pnl_lat, frame_start, frame_done, pnl_r1, pnl_r2}, 6'b0);
        check("rst_addr", {fb_col_addr, pnl_addr}, 11'd0);

        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // Frame 1: shifting, latch timing, pixel data, brightness cases
        enable = 1'b1;
        @(negedge clk);
        check("fs_after_en", frame_start, 1'b1);
        check("busy_run", busy, 1'b1);

        run_row(-1, 8'd0);
        check("r0_rises", r_rises, 64);
        check("r0_lat_at", r_lat_at, 192);
        check("r0_lat_cnt", r_lat_cnt, 1);
        check("r0_addr", r_addr, 0);
        check("r0_oe_cnt", r_oe_cnt, 100);
        check("r0_oe_first", r_oe_first, 193);
        check("r0_r1", r_r1, 64'h0);
        check("r0_r2", r_r2, 64'h20);
        check("r0_fs_cnt", r_fs_cnt, 1);

        run_row(-1, 8'd0);
        check("r1_addr", r_addr, 1);
        check("r1_oe_cnt", r_oe_cnt, 100);

        brightness = 8'd50;
        run_row(300, 8'd200);
        check("r2_oe_cnt", r_oe_cnt, 50);

        run_row(-1, 8'd0);
        check("r3_oe_cnt", r_oe_cnt, 200);
        check("r3_r1", r_r1, 64'h20);
        check("r3_r2", r_r2, 64'h0);
        check("r3_addr", r_addr, 3);

        brightness = 8'd0;
        run_row(-1, 8'd0);
        check("r4_oe_cnt", r_oe_cnt, 0);

        brightness = 8'd255;
        run_row(-1, 8'd0);
        check("r5_oe_cnt", r_oe_cnt, 255);
        check("r5_oe_first", r_oe_first, 193);

        brightness = 8'd100;
        fs_sum = 0;
        fd_sum = 0;
        for (int r = 6; r < 32; r++) begin
            run_row(-1, 8'd0);
            fs_sum += r_fs_cnt;
            fd_sum += r_fd_cnt;
        end
        check("f1_r31_fd_at", r_fd_at, 448);
        check("f1_r31_addr", r_addr, 31);
        check("f1_fs_sum", fs_sum, 0);
        check("f1_fd_sum", fd_sum, 1);
        check("f2_fs_period", frame_start, 1'b1);

        // Frame 2: enable drops at row 10, frame still completes
        for (int r = 0; r < 10; r++) run_row(-1, 8'd0);
        enable = 1'b0;
        fd_sum = 0;
        for (int r = 10; r < 32; r++) begin
            run_row(-1, 8'd0);
            fd_sum += r_fd_cnt;
        end
        check("f2_r31_fd_at", r_fd_at, 448);
        check("f2_fd_sum", fd_sum, 1);
        check("f2_idle_busy", busy, 1'b0);
        check("f2_idle_oe_n", pnl_oe_n, 1'b1);
        fs_sum   = 0;
        busy_sum = 0;
        for (int i = 0; i < 600; i++) begin
            if (frame_start) fs_sum++;
            if (busy) busy_sum++;
            @(negedge clk);
        end
        check("idle_no_fs", fs_sum, 0);
        check("idle_no_busy", busy_sum, 0);

        // Frame 3: asynchronous reset in the CLK phase of row 7, col 20
        enable = 1'b1;
        @(negedge clk);
        check("f3_fs", frame_start, 1'b1);
        for (int r = 0; r < 7; r++) run_row(-1, 8'd0);
        repeat (62) @(negedge clk);
        check("pre_rst_clk", pnl_clk, 1'b1);
        check("pre_rst_col", fb_col_addr, 6'd20);
        check("pre_rst_addr", pnl_addr, 5'd6);
        rst_n = 1'b0;
        #1;
        check("arst_oe_n", pnl_oe_n, 1'b1);
        check("arst_clk", pnl_clk, 1'b0);
        check("arst_lat", pnl_lat, 1'b0);
        check("arst_addr", pnl_addr, 5'd0);
        check("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_fs", frame_start, 1'b1);
        run_row(-1, 8'd0);
        check("rst_r0_addr", r_addr, 0);
        check("rst_r0_rises", r_rises, 64);
        check("rst_r0_oe_cnt", r_oe_cnt, 100);

        enable = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_panel_scan.md
Name: led_panel_scan

Overview:
- Reader side of the 64x64 game framebuffer; the frame builder writes it, this block reads it.
- Reads the framebuffer one column at a time and drives a monochrome HUB75-style 64x64 panel with 1/32 scan.
- Each scan row shows pixel row r on the upper half and row r+32 on the lower half.
- Sits between the framebuffer RAM and the panel pins; issues frame_start/frame_done so the writer can update without tearing.

Parameters:
COLS, 64, pixels shifted per scan row (framebuffer column count x)
SCAN_ROWS, 32, scan rows per frame (panel height / 2)
ON_CYCLES, 256, length of the DISPLAY window per scan row, in clk cycles
BRIGHT_W, 8, width of brightness input

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run scanning; sampled at frame boundaries
brightness  in  BRIGHT_W  oe-on cycles per DISPLAY window; sampled in LATCH
fb_col_addr  out  6  framebuffer column (x) read address; registered
fb_col_data  in  64  column x contents, bit y = pixel (x,y); valid the cycle after fb_col_addr changes
pnl_clk  out  1  panel shift clock
pnl_r1  out  1  upper-half pixel data (y = row)
pnl_r2  out  1  lower-half pixel data (y = row+32)
pnl_lat  out  1  panel latch strobe, active high
pnl_oe_n  out  1  panel output enable, active low
pnl_addr  out  5  panel row address
frame_start  out  1  one-cycle pulse on first ADDR cycle of row 0
frame_done  out  1  one-cycle pulse on last DISPLAY cycle of row SCAN_ROWS-1
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock is clk; reset is asynchronous and active-low on rst_n. All state is reset by rst_n low.
- Reset values:
  - state=IDLE, row=0, col=0.
  - fb_col_addr=0, pnl_clk=0, pnl_r1=0, pnl_r2=0, pnl_lat=0, pnl_oe_n=1, pnl_addr=0.
  - frame_start=0, frame_done=0, busy=0.
- All outputs are registered.
- States:
  - IDLE: outputs at reset values. enable=1 -> SHIFT with row=0, col=0.
  - SHIFT: 3-cycle phase counter per pixel, col = 0..COLS-1.
    - ADDR: fb_col_addr<=col, pnl_clk=0.
    - SETUP: pnl_r1<=fb_col_data[row], pnl_r2<=fb_col_data[row+32], pnl_clk=0.
    - CLK: pnl_clk=1.
    - pnl_oe_n=1 throughout SHIFT.
    - After the CLK phase of col=COLS-1 -> LATCH. SHIFT lasts exactly 3*COLS=192 cycles.
  - LATCH: 1 cycle; pnl_lat=1, pnl_clk=0, pnl_addr<=row, bright_q<=brightness. Then -> DISPLAY, disp_cnt=0.
  - DISPLAY: ON_CYCLES cycles.
    - pnl_oe_n=0 iff disp_cnt < bright_q. Brightness 0 -> fully dark; brightness >= ON_CYCLES -> on for the whole window.
    - At the last cycle: if row<SCAN_ROWS-1 then row++ and -> SHIFT.
    - Otherwise frame_done=1, row=0; enable=1 -> SHIFT, enable=0 -> IDLE.
- Row period is 192+1+256 = 449 cycles; frame period is 32*449 = 14368 cycles.
- frame_start is asserted in the ADDR cycle of col 0 when row=0.
- enable dropping mid-frame does not abort: the current frame completes, then the block goes to IDLE.
- enable is ignored except in IDLE and at the end of the frame.
- pnl_r1/pnl_r2 hold their value through CLK and until the next SETUP.
- Row/col counters saturate by wrap: col wraps 63->0 at LATCH, row wraps 31->0 at frame end.
- brightness changes mid-DISPLAY take effect at the next LATCH only.
- rst_n asserted mid-operation: immediate return to reset values, including pnl_oe_n=1 (panel dark) and no partial latch pulse.

Decomposition:
- Shared package (led_pkg):
  - constants PANEL_COLS=64, PANEL_SCAN_ROWS=32, PIX_PHASES=3.
  - enum scan_state_t {IDLE, SHIFT, LATCH, DISPLAY}.
  - enum pix_phase_t {ADDR, SETUP, CLK}.
- One natural sub-module: led_pwm_gate (disp_cnt counter plus compare against bright_q producing pnl_oe_n).
- The rest stays in one FSM.

Test Plan:
- Reset, then enable=1, framebuffer all zero -> frame_start at cycle 1 after enable is seen; 64 pnl_clk rising edges per row; pnl_lat high exactly 1 cycle, 193 cycles after row start; frame_done 14368 cycles after frame_start.
- Framebuffer column 5 = 64'h0000_0001_0000_0008 (bits 3 and 32) -> row 3: pnl_r1=1 only for the 6th shifted pixel; row 0: pnl_r2=1 only for the 6th pixel; all other pixels 0.
- brightness=100 -> pnl_oe_n low exactly 100 cycles per row, starting the cycle after LATCH. brightness=0 -> pnl_oe_n never low. brightness=255 -> low 255 of 256 cycles.
- enable deasserted at row 10 -> scanning continues to row 31, frame_done pulses, busy falls the next cycle, pnl_oe_n=1; no further frame_start.
- rst_n pulsed low during SHIFT of row 7, col 20 -> same cycle (async): pnl_oe_n=1, pnl_clk=0, pnl_lat=0, pnl_addr=0. After release with enable=1, the frame restarts at row 0 with frame_start.
- brightness changed from 50 to 200 mid-DISPLAY of row 2 -> row 2 still 50 on-cycles; row 3 shows 200.
